hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller that drives the ID/EXE pipeline register's control side. It tracks instructions in flight in its own shadow scoreboard, which mirrors the EXE and MEM stages. From that it decides, every cycle, whether the ID-stage instruction issues, is replaced by a bubble, or is killed. It produces the freeze and flush strobes for the IF/ID and ID/EXE registers and the back-end freeze used during multi-cycle data-memory accesses. It sits beside the ID stage and observes ID-stage decode outputs, the EXE-stage branch decision and the data-memory ready handshake.

## Interface
- FWD_EN, 1: 1 = forwarding unit present, stall only on load-use; 0 = stall on any RAW against EXE or MEM.
- MAX_WAIT, 255: memory wait cycles before timeout release (1..65535).
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- id_valid  in  1  ID stage holds a real instruction.
- id_src1, id_src2  in  5 each  ID source registers.
- id_two_regs  in  1  id_src2 is a true source (R-type / store / branch).
- id_dest  in  5  ID destination register.
- id_wb_en, id_mem_read, id_mem_write  in  1 each  ID control bits.
- branch_taken  in  1  EXE-stage branch resolved taken this cycle.
- mem_ready  in  1  data memory completes the current access this cycle.
- freeze_if  out  1  hold PC and IF/ID.
- flush_ifid  out  1  load bubble into IF/ID.
- flush_idexe  out  1  load bubble into ID/EXE.
- freeze_back  out  1  hold ID/EXE, EXE/MEM, MEM/WB.
- mem_req  out  1  MEM-stage instruction is a memory access.
- mem_timeout  out  1  sticky: a memory wait hit MAX_WAIT.
- stall_cnt  out  16  saturating count of stalled cycles.

## Operation
- Scoreboard: slots EXE and MEM, each {valid, dest, wb_en, mem_read, mem_write}; reset all zero.
- mem_req = MEM.valid & (MEM.mem_read | MEM.mem_write).
- mem_stall = mem_req & ~mem_ready & ~release. release is 1 in the cycle the wait counter equals MAX_WAIT.
- match(slot, r) = r != 0 & slot.valid & slot.wb_en & slot.dest == r. A src2 match counts only when id_two_regs = 1.
- raw: FWD_EN=1 → a match on EXE with EXE.mem_read = 1; FWD_EN=0 → a match on EXE or MEM.
- hazard = id_valid & raw.
- Priority per cycle, highest first:
  - mem_stall: freeze_if=1, freeze_back=1, flush_*=0. Scoreboard holds.
  - branch_taken: flush_ifid=1, flush_idexe=1, freeze_if=0. Scoreboard shifts, EXE ← bubble.
  - hazard: freeze_if=1, flush_idexe=1. Scoreboard shifts, EXE ← bubble.
  - otherwise: all strobes 0. Scoreboard shifts, EXE ← ID fields with valid = id_valid.
- Shift means MEM ← EXE.
- FSM states:
  - RUN: mem_stall → WAIT, counter ← 1.
  - WAIT: each mem_stall cycle counter += 1. mem_ready or release → RUN, counter ← 0. release also sets mem_timeout.
- mem_timeout is cleared only by reset.
- stall_cnt increments on every cycle with freeze_if = 1 and saturates at 0xFFFF.

## Timing
- Strobes are combinational from state and current inputs and take effect at the next rising edge. Latency from hazard to stall is 0 cycles.
- Register-file writes occur before reads within a cycle, so the WB stage is never checked.
- Load-use (FWD_EN=1) costs exactly 1 bubble.
- No-forwarding RAW costs 2 bubbles behind EXE and 1 behind MEM.
- Branch costs 2 killed instructions.
- A branch_taken coinciding with mem_stall is ignored that cycle. EXE holds the branch, so it reasserts after the stall.
- While reset is high: all outputs 0, state RUN, counters 0. Reset mid-WAIT abandons the access with no timeout flag.
- MAX_WAIT=1 means a stalled access is released after 1 cycle.

## Test plan
- Load-use, FWD_EN=1: lw r2 then add r3,r2,r1 → one cycle freeze_if=1, flush_idexe=1. The add issues the next cycle. stall_cnt=1.
- No forwarding, FWD_EN=0: add r5,… then sub r6,r5,r0 → two consecutive bubble cycles. Same sequence with src r0 → no stall.
- Branch: branch_taken pulse with ID holding a hazard → flush_ifid=flush_idexe=1, freeze_if=0. EXE slot is a bubble.
- Memory wait: sw in MEM, mem_ready low 3 cycles → freeze_back=1 for exactly 3 cycles, then RUN. mem_timeout=0.
- Timeout: MAX_WAIT=4, mem_ready never asserted → release on cycle 4, mem_timeout=1 and remains 1 until reset.
- Async reset asserted mid-WAIT between clock edges → outputs 0 immediately. stall_cnt=0 and mem_timeout=0 after release.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the ID-stage decode fields, the EXE branch
// decision, the data-memory handshake and the pipeline control strobes
// exchanged between the pipeline (master) and hazard_ctrl (slave).
//   id_*          ID-stage instruction fields (master -> slave)
//   branch_taken  EXE-stage branch resolved taken (master -> slave)
//   mem_ready     data memory completes current access (master -> slave)
//   freeze_if, flush_ifid, flush_idexe, freeze_back  pipeline strobes
//   mem_req, mem_timeout, stall_cnt                  status (slave -> master)
interface hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_src1;
  logic [4:0]  id_src2;
  logic        id_two_regs;
  logic [4:0]  id_dest;
  logic        id_wb_en;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        branch_taken;
  logic        mem_ready;
  logic        freeze_if;
  logic        flush_ifid;
  logic        flush_idexe;
  logic        freeze_back;
  logic        mem_req;
  logic        mem_timeout;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_regs, id_dest,
           id_wb_en, id_mem_read, id_mem_write, branch_taken, mem_ready,
    input  freeze_if, flush_ifid, flush_idexe, freeze_back,
           mem_req, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_regs, id_dest,
           id_wb_en, id_mem_read, id_mem_write, branch_taken, mem_ready,
    output freeze_if, flush_ifid, flush_idexe, freeze_back,
           mem_req, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the ID/EXE boundary.
// Keeps a shadow scoreboard of the EXE and MEM stages and decides each cycle
// whether the ID instruction issues, is replaced by a bubble, or is killed.
// Also freezes the back end while a data-memory access is outstanding, with
// a MAX_WAIT timeout that releases the access and sets a sticky flag.
// Ports:
//   clock  pipeline clock (rising edge)
//   reset  asynchronous active-high reset
//   bus    hazard_ctrl_if.slave: ID fields, branch_taken, mem_ready in;
//          freeze/flush strobes, mem_req, mem_timeout, stall_cnt out
// Parameters:
//   FWD_EN    1 = stall only on load-use, 0 = stall on any RAW vs EXE/MEM
//   MAX_WAIT  memory wait cycles before timeout release (1..65535)
module hazard_ctrl #(
  parameter bit          FWD_EN   = 1'b1,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wb_en;
    logic       mem_read;
    logic       mem_write;
  } slot_t;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t      state_q, state_d;
  slot_t       exe_q, exe_d, mem_q, mem_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] stall_q, stall_d;
  logic        tout_q, tout_d;

  logic req, rel, mem_stall, hit_exe, hit_mem, raw, hazard;
  logic freeze_if_c, flush_ifid_c, flush_idexe_c, freeze_back_c;
  slot_t id_slot;

  function automatic logic match(input slot_t s, input logic [4:0] r);
    return (r != 5'd0) && s.valid && s.wb_en && (s.dest == r);
  endfunction

  always_comb begin
    id_slot = '{valid:     bus.id_valid,
                dest:      bus.id_dest,
                wb_en:     bus.id_wb_en,
                mem_read:  bus.id_mem_read,
                mem_write: bus.id_mem_write};

    req       = mem_q.valid & (mem_q.mem_read | mem_q.mem_write);
    // In RUN the counter is 0 and MAX_WAIT >= 1, so release only fires in WAIT.
    rel       = (wait_q == 16'(MAX_WAIT));
    mem_stall = req & ~bus.mem_ready & ~rel;

    hit_exe = match(exe_q, bus.id_src1) | (bus.id_two_regs & match(exe_q, bus.id_src2));
    hit_mem = match(mem_q, bus.id_src1) | (bus.id_two_regs & match(mem_q, bus.id_src2));
    raw     = FWD_EN ? (hit_exe & exe_q.mem_read) : (hit_exe | hit_mem);
    hazard  = bus.id_valid & raw;

    freeze_if_c   = 1'b0;
    flush_ifid_c  = 1'b0;
    flush_idexe_c = 1'b0;
    freeze_back_c = 1'b0;
    exe_d         = exe_q;
    mem_d         = mem_q;

    // Strobes are gated by reset so a live branch_taken input cannot leak
    // through while the block is held in reset.
    if (!reset) begin
      if (mem_stall) begin
        freeze_if_c   = 1'b1;
        freeze_back_c = 1'b1;
      end else begin
        mem_d = exe_q;
        if (bus.branch_taken) begin
          flush_ifid_c  = 1'b1;
          flush_idexe_c = 1'b1;
          exe_d         = '0;
        end else if (hazard) begin
          freeze_if_c   = 1'b1;
          flush_idexe_c = 1'b1;
          exe_d         = '0;
        end else begin
          exe_d = id_slot;
        end
      end
    end

    stall_d = (freeze_if_c && (stall_q != '1)) ? stall_q + 16'd1 : stall_q;

    state_d = state_q;
    wait_d  = wait_q;
    tout_d  = tout_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_WAIT;
          wait_d  = 16'd1;
        end
      end
      ST_WAIT: begin
        if (mem_stall) begin
          wait_d = wait_q + 16'd1;
        end else begin
          state_d = ST_RUN;
          wait_d  = '0;
          if (rel) tout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      exe_q   <= '0;
      mem_q   <= '0;
      wait_q  <= '0;
      stall_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exe_q   <= exe_d;
      mem_q   <= mem_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.freeze_if   = freeze_if_c;
  assign bus.flush_ifid  = flush_ifid_c;
  assign bus.flush_idexe = flush_idexe_c;
  assign bus.freeze_back = freeze_back_c;
  assign bus.mem_req     = req & ~reset;
  assign bus.mem_timeout = tout_q;
  assign bus.stall_cnt   = stall_q;

endmodule
